imem_axil_responder: RTL and testbench

AXI-lite read-only responder serving instruction words from an on-chip word-addressed memory. It sits on the far side of the fetch unit's AR/R read channel: it accepts one read address per handshake, reads the addressed 32-bit word and returns it on the R channel with a response code. A side load port lets the testbench or boot logic write program words into the array.

---
 rtl/imem_axil_responder_if.sv | 30 +++
 rtl/imem_axil_responder.sv | 113 +++++++++++
 tb/tb_imem_axil_responder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_axil_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_axil_responder_if
//  Description : AXI-lite read-only channel bundle (AR + R) between an
//                instruction-fetch initiator and the imem responder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface imem_axil_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        output ARADDR, ARVALID, RREADY,
        input  ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  ARADDR, ARVALID, RREADY,
        output ARREADY, RDATA, RRESP, RVALID
    );
endinterface
`default_nettype wire

// File: rtl/imem_axil_responder.sv
`default_nettype none
// ============================================================================
//  Module      : imem_axil_responder
//  Description : AXI-lite read-only responder returning 32-bit instruction
//                words from an on-chip word-addressed array, with a side
//                load port for program download. One read in flight at a
//                time: IDLE -> READ -> RESP -> IDLE.
//  Options     : IMEM_ADDR_CHECK_EN - when defined, misaligned or
//                out-of-range addresses return SLVERR with zero data;
//                when undefined, addresses wrap modulo MEM_DEPTH words.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_axil_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int IDX_W      = $clog2(MEM_DEPTH)
) (
    input  wire logic                  clk,
    input  wire logic                  rst,      // asynchronous, active-low
    imem_axil_responder_if.slave       axi,
    input  wire logic                  ld_we,
    input  wire logic [IDX_W-1:0]      ld_addr,
    input  wire logic [DATA_WIDTH-1:0] ld_data
);

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr_q;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_err;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Handshake outputs decode straight from the state register; reset
    // forces IDLE asynchronously so RVALID drops the moment rst goes low.
    assign axi.ARREADY = (r_state == S_IDLE) & rst;
    assign axi.RVALID  = (r_state == S_RESP);
    assign axi.RDATA   = r_rdata;
    assign axi.RRESP   = r_rresp;

    assign w_idx = r_addr_q[IDX_W+1:2];

`ifdef IMEM_ADDR_CHECK_EN
    // Flag byte-misaligned addresses and any address beyond the array.
    assign w_err = (r_addr_q[1:0] != 2'b00) ||
                   (r_addr_q[ADDR_WIDTH-1:IDX_W+2] != '0);
`else
    // Without checking, the byte offset and upper bits simply wrap away.
    logic w_unused_addr;
    assign w_err         = 1'b0;
    assign w_unused_addr = ^{r_addr_q[1:0], r_addr_q[ADDR_WIDTH-1:IDX_W+2]};
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state logic: accept one address, read for one cycle, then hold
    // the response until the initiator takes it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (axi.ARVALID) w_state_nxt = S_READ;
            S_READ:  w_state_nxt = S_RESP;
            S_RESP:  if (axi.RREADY) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Capture the read address on the AR handshake (ARREADY is high in IDLE).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                               r_addr_q <= '0;
        else if (r_state == S_IDLE && axi.ARVALID) r_addr_q <= axi.ARADDR;
    end

    // Read the array in READ; the registered result is held through RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
            r_rresp <= c_RESP_OKAY;
        end else if (r_state == S_READ) begin
            if (w_err) begin
                r_rdata <= '0;
                r_rresp <= c_RESP_SLVERR;
            end else begin
                r_rdata <= mem[w_idx];
                r_rresp <= c_RESP_OKAY;
            end
        end
    end

    // Load port writes are independent of the AXI side; a same-edge read
    // of the same index sees the old word.
    always_ff @(posedge clk) begin
        if (ld_we) mem[ld_addr] <= ld_data;
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_axil_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_axil_responder
//  Description : Directed self-checking bench for imem_axil_responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_axil_responder;

    localparam int c_AW    = 32;
    localparam int c_DW    = 32;
    localparam int c_DEPTH = 1024;
    localparam int c_IW    = 10;

    logic            clk;
    logic            rst;
    logic            ld_we;
    logic [c_IW-1:0] ld_addr;
    logic [c_DW-1:0] ld_data;

    int n_vec;
    int n_err;

    imem_axil_responder_if #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW)) axi ();

    imem_axil_responder #(
        .ADDR_WIDTH(c_AW),
        .DATA_WIDTH(c_DW),
        .MEM_DEPTH (c_DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .axi    (axi.slave),
        .ld_we  (ld_we),
        .ld_addr(ld_addr),
        .ld_data(ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [c_IW-1:0] idx, input logic [31:0] data);
        ld_we   = 1'b1;
        ld_addr = idx;
        ld_data = data;
        step();
        ld_we   = 1'b0;
    endtask

    // Full read with RREADY held high: handshake, READ, RESP, back to IDLE
    // in exactly three edges.
    task automatic rd(input string tag, input logic [31:0] addr,
                      input logic [31:0] exp_data, input logic [1:0] exp_resp);
        chk({tag, "_arready_pre"}, 32'(axi.ARREADY), 32'd1);
        axi.ARADDR  = addr;
        axi.ARVALID = 1'b1;
        axi.RREADY  = 1'b1;
        step();
        axi.ARVALID = 1'b0;
        chk({tag, "_rvalid_n1"},  32'(axi.RVALID),  32'd0);
        chk({tag, "_arready_n1"}, 32'(axi.ARREADY), 32'd0);
        step();
        chk({tag, "_rvalid_n2"}, 32'(axi.RVALID), 32'd1);
        chk({tag, "_rdata"},     axi.RDATA,       exp_data);
        chk({tag, "_rresp"},     32'(axi.RRESP),  32'(exp_resp));
        step();
        chk({tag, "_rvalid_done"},  32'(axi.RVALID),  32'd0);
        chk({tag, "_arready_done"}, 32'(axi.ARREADY), 32'd1);
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b0;
        ld_we       = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;
        axi.ARADDR  = '0;
        axi.ARVALID = 1'b0;
        axi.RREADY  = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_arready", 32'(axi.ARREADY), 32'd0);
        chk("rst_rvalid",  32'(axi.RVALID),  32'd0);
        chk("rst_rdata",   axi.RDATA,        32'd0);
        chk("rst_rresp",   32'(axi.RRESP),   32'd0);
        rst = 1'b1;
        step();
        chk("rel_arready", 32'(axi.ARREADY), 32'd1);

        // Program load and back-to-back reads (one per 3 cycles)
        load(10'd0, 32'h0000_0013);
        load(10'd1, 32'h0010_0093);
        load(10'd2, 32'h0020_0113);
        load(10'd3, 32'h0030_0193);
        rd("rd0",  32'h0, 32'h0000_0013, 2'b00);
        rd("rd4",  32'h4, 32'h0010_0093, 2'b00);
        rd("rd8",  32'h8, 32'h0020_0113, 2'b00);
        rd("rd12", 32'hC, 32'h0030_0193, 2'b00);

        // Backpressure: response held, AR ignored
        axi.RREADY  = 1'b0;
        axi.ARADDR  = 32'h4;
        axi.ARVALID = 1'b1;
        step();
        axi.ARVALID = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            axi.ARADDR  = 32'h8;
            axi.ARVALID = i[0];
            chk("bp_rvalid",  32'(axi.RVALID),  32'd1);
            chk("bp_rdata",   axi.RDATA,        32'h0010_0093);
            chk("bp_arready", 32'(axi.ARREADY), 32'd0);
            step();
        end
        axi.ARVALID = 1'b0;
        axi.RREADY  = 1'b1;
        step();
        axi.RREADY  = 1'b0;
        chk("bp_arready_after", 32'(axi.ARREADY), 32'd1);
        chk("bp_rvalid_after",  32'(axi.RVALID),  32'd0);

        // Out-of-range / misaligned
`ifdef IMEM_ADDR_CHECK_EN
        rd("oor",  32'h1000, 32'h0, 2'b10);
        rd("mis6", 32'h6,    32'h0, 2'b10);
`else
        rd("oor",  32'h1000, 32'h0000_0013, 2'b00);
        rd("mis6", 32'h6,    32'h0010_0093, 2'b00);
`endif

        // Load/read collision on the READ edge: old word returned
        load(10'd5, 32'hAAAA_5555);
        axi.ARADDR  = 32'h14;
        axi.ARVALID = 1'b1;
        axi.RREADY  = 1'b0;
        step();
        axi.ARVALID = 1'b0;
        ld_we   = 1'b1;
        ld_addr = 10'd5;
        ld_data = 32'h1234_5678;
        step();
        ld_we   = 1'b0;
        chk("col_rvalid", 32'(axi.RVALID), 32'd1);
        chk("col_rdata",  axi.RDATA,       32'hAAAA_5555);
        axi.RREADY = 1'b1;
        step();
        rd("col_new", 32'h14, 32'h1234_5678, 2'b00);

        // Reset mid-transaction while in RESP with RREADY low
        axi.RREADY  = 1'b0;
        axi.ARADDR  = 32'h8;
        axi.ARVALID = 1'b1;
        step();
        axi.ARVALID = 1'b0;
        step();
        chk("mid_rvalid_pre", 32'(axi.RVALID), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rvalid_async", 32'(axi.RVALID),  32'd0);
        chk("mid_arready",      32'(axi.ARREADY), 32'd0);
        chk("mid_rdata",        axi.RDATA,        32'd0);
        step();
        rst = 1'b1;
        #1;
        chk("mid_arready_rel", 32'(axi.ARREADY), 32'd1);
        axi.RREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_no_stale", 32'(axi.RVALID), 32'd0);
        end
        rd("post_rst", 32'h8, 32'h0020_0113, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Bound the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
